tag_multicaster: RTL and testbench
==================================

Name: tag_multicaster

Overview:
- Per-column multicaster between the global operand bus and one PE.
- Accepts ifmap, filter and partial-sum words only when the bus tag matches the column ID, and buffers each class in its own small FIFO.
- Presents complete operand triples to the PE with a valid/ready handshake.
- Returns each PE result to the bus as a registered psum with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 16: ifmap/filter word width; psum width is 2*DATA_WIDTH.
- NUM_COL, 4: columns on the bus; ID/TAG width is IDW = $clog2(NUM_COL).
- FIFO_DEPTH, 2: entries per operand FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id  in  IDW  column ID, static after reset
- bus_tag  in  IDW  destination tag of the current bus word
- bus_en  in  3  class enables: [0] ifmap, [1] fltr, [2] psum
- bus_ifmap  in  DATA_WIDTH  ifmap word
- bus_fltr  in  DATA_WIDTH  filter word
- bus_psum  in  2*DATA_WIDTH  psum word
- caster_ready  out  1  all three FIFOs have space
- caster_valid  out  1  psum_m2b holds a new result (one-cycle pulse)
- psum_m2b  out  2*DATA_WIDTH  result psum to bus
- ifmap_m2b  out  DATA_WIDTH  last ifmap issued to the PE (neighbour reuse)
- fltr_m2b  out  DATA_WIDTH  last filter issued to the PE
- pe_en  out  1  operand triple valid to PE
- pe_ready  in  1  PE accepts triple
- pe_ifmap  out  DATA_WIDTH  ifmap FIFO head
- pe_fltr  out  DATA_WIDTH  fltr FIFO head
- pe_psum  out  2*DATA_WIDTH  psum FIFO head
- pe_valid  in  1  PE result valid
- pe_psum_res  in  2*DATA_WIDTH  PE result psum

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All FIFOs emptied; pointers and counts set to 0.
  - caster_valid=0, psum_m2b=0, ifmap_m2b=0, fltr_m2b=0.
  - caster_ready=0 during the reset cycle, 1 from the first cycle after reset.
  - Reset mid-operation discards buffered operands and drops any pending pe_valid; no partial triple survives.
- Tag match: match = (bus_tag == id).
- caster_ready:
  - Asserted when cnt_ifmap, cnt_fltr and cnt_psum are all < FIFO_DEPTH.
  - Computed from current occupancy only: a same-cycle pop does not open space.
- Bus push:
  - Occurs at the edge when match && caster_ready && bus_en != 0.
  - Each enabled class pushes its word into its FIFO.
  - Classes not enabled are unchanged.
  - Mismatched tag, or caster_ready=0: the word is dropped silently, no state change.
  - The bus must hold its word until caster_ready is seen high; flow control is the bus's responsibility.
- PE issue:
  - pe_en = all three FIFOs non-empty; combinational from registered counts.
  - pe_ifmap, pe_fltr and pe_psum are the FIFO heads, registered storage with no combinational path from the bus.
  - Fire = pe_en && pe_ready: pops one entry from each FIFO; ifmap_m2b and fltr_m2b capture the popped heads next cycle.
  - pe_ready with pe_en=0: no effect.
- Latency:
  - A word pushed at edge N is visible at the FIFO head after edge N.
  - pe_en can rise in cycle N+1 if the other classes are already present.
- Push and pop in the same cycle on one FIFO: count unchanged, both pointers advance, wrap modulo FIFO_DEPTH.
- Result return:
  - pe_valid=1 at an edge: psum_m2b <= pe_psum_res and caster_valid=1 for exactly that next cycle.
  - psum_m2b holds until the next result; no backpressure on the return path.
  - Back-to-back pe_valid gives consecutive pulses.
- Arithmetic: no data arithmetic; counts are $clog2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH.

Optional Feature:
MCASTER_BCAST_EN
- Defined:
  - Adds input port bus_bcast (1 bit).
  - match = (bus_tag == id) || bus_bcast, so every column accepts the word regardless of tag.
  - Push rules are otherwise unchanged.
- Undefined: the port is absent and match is the tag compare only.

Test Plan:
- Reset, id=2, bus_tag=2, bus_en=3'b111, ifmap=0x0011, fltr=0x0022, psum=0x00000033 for one cycle; pe_ready=1 -> next cycle pe_en=1 with those three values; the following cycle pe_en=0 and ifmap_m2b=0x0011, fltr_m2b=0x0022.
- bus_tag=1 with id=2, bus_en=3'b111 -> no push; pe_en stays 0; caster_ready stays 1.
- pe_ready=0; push 2 triples (FIFO_DEPTH=2) -> caster_ready=0; a third triple is dropped; release pe_ready -> exactly 2 triples issue, in order.
- Staggered classes: ifmap at cycle 1, fltr at cycle 3, psum at cycle 5 -> pe_en first high in cycle 6.
- pe_valid pulses with 0x12345678 then 0x9ABCDEF0 on consecutive cycles -> caster_valid high two consecutive cycles, psum_m2b follows the same order.
- rst asserted while 1 triple is buffered and pe_valid=1 -> next cycle pe_en=0, caster_valid=0, psum_m2b=0.

Source files
------------

// File: rtl/tag_multicaster.sv
// tag_multicaster
//   Per-column multicaster between the global operand bus and one PE.
//   Bus words whose tag matches this column's ID are buffered per class
//   (ifmap / filter / psum) in small FIFOs. A complete operand triple is
//   presented to the PE with a valid/ready handshake. PE results go back to
//   the bus as a registered psum with a one-cycle valid pulse.
//
//   Optional build macro: MCASTER_BCAST_EN
//     When defined, the design adds the bus_bcast input. With bus_bcast high,
//     every column accepts the bus word whatever its tag.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id                       column ID (static after reset)
//   bus_tag, bus_en          destination tag, class enables {psum, fltr, ifmap}
//   bus_ifmap/fltr/psum      bus operand words
//   bus_bcast                broadcast accept (MCASTER_BCAST_EN only)
//   caster_ready             all three FIFOs have space
//   caster_valid, psum_m2b   result pulse and registered result to the bus
//   ifmap_m2b, fltr_m2b      last operands issued to the PE (neighbour reuse)
//   pe_en, pe_ready          operand triple handshake to the PE
//   pe_ifmap/fltr/psum       FIFO heads
//   pe_valid, pe_psum_res    PE result input
module tag_multicaster #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int FIFO_DEPTH = 2,
  localparam int IDW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  localparam int PW  = $clog2(FIFO_DEPTH),
  localparam int CW  = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDW-1:0]          id,
  input  logic [IDW-1:0]          bus_tag,
  input  logic [2:0]              bus_en,
  input  logic [DATA_WIDTH-1:0]   bus_ifmap,
  input  logic [DATA_WIDTH-1:0]   bus_fltr,
  input  logic [2*DATA_WIDTH-1:0] bus_psum,
`ifdef MCASTER_BCAST_EN
  input  logic                    bus_bcast,
`endif
  output logic                    caster_ready,
  output logic                    caster_valid,
  output logic [2*DATA_WIDTH-1:0] psum_m2b,
  output logic [DATA_WIDTH-1:0]   ifmap_m2b,
  output logic [DATA_WIDTH-1:0]   fltr_m2b,
  output logic                    pe_en,
  input  logic                    pe_ready,
  output logic [DATA_WIDTH-1:0]   pe_ifmap,
  output logic [DATA_WIDTH-1:0]   pe_fltr,
  output logic [2*DATA_WIDTH-1:0] pe_psum,
  input  logic                    pe_valid,
  input  logic [2*DATA_WIDTH-1:0] pe_psum_res
);

  logic              match;
  logic              push_all;
  logic [2:0]        push_cls;
  logic [2:0]        not_empty;
  logic [2:0]        not_full;
  logic              fire;
  logic [2:0][PW-1:0] wr_ptr;
  logic [2:0][PW-1:0] rd_ptr;

`ifdef MCASTER_BCAST_EN
  assign match = (bus_tag == id) || bus_bcast;
`else
  assign match = (bus_tag == id);
`endif

  // Held low while rst is asserted so the bus never sees space during reset.
  // Space is judged on current occupancy only; a same-cycle pop does not help.
  assign caster_ready = !rst && (&not_full);
  assign push_all     = match && caster_ready && (bus_en != 3'b000);
  assign push_cls     = bus_en & {3{push_all}};

  assign pe_en = &not_empty;
  assign fire  = pe_en && pe_ready;

  // Occupancy and pointers, one set per class (0 ifmap, 1 fltr, 2 psum).
  // All three pop together on fire; each pushes on its own enable.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cls
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;

    always_comb begin
      cnt_next = cnt_reg;
      if (push_cls[gi] && !fire) begin
        cnt_next = cnt_reg + CW'(1);
      end else if (!push_cls[gi] && fire) begin
        cnt_next = cnt_reg - CW'(1);
      end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg    <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
        if (push_cls[gi]) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (fire)         rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end

    assign not_empty[gi] = (cnt_reg != '0);
    assign not_full[gi]  = (cnt_reg < CW'(FIFO_DEPTH));
    assign wr_ptr[gi]    = wr_ptr_reg;
    assign rd_ptr[gi]    = rd_ptr_reg;
  end

  // Operand storage. Contents need no reset: empty counts make them invisible.
  logic [DATA_WIDTH-1:0]   ifmap_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fltr_mem  [FIFO_DEPTH];
  logic [2*DATA_WIDTH-1:0] psum_mem  [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push_cls[0]) ifmap_mem[wr_ptr[0]] <= bus_ifmap;
    if (push_cls[1]) fltr_mem[wr_ptr[1]]  <= bus_fltr;
    if (push_cls[2]) psum_mem[wr_ptr[2]]  <= bus_psum;
  end

  // Heads are read from registered storage with registered pointers, so a
  // word pushed at an edge is visible right after that edge with no bus path.
  assign pe_ifmap = ifmap_mem[rd_ptr[0]];
  assign pe_fltr  = fltr_mem[rd_ptr[1]];
  assign pe_psum  = psum_mem[rd_ptr[2]];

  // Issued-operand copies and the result return path.
  logic [DATA_WIDTH-1:0]   ifmap_m2b_reg;
  logic [DATA_WIDTH-1:0]   fltr_m2b_reg;
  logic [2*DATA_WIDTH-1:0] psum_m2b_reg;
  logic                    caster_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ifmap_m2b_reg    <= '0;
      fltr_m2b_reg     <= '0;
      psum_m2b_reg     <= '0;
      caster_valid_reg <= 1'b0;
    end else begin
      if (fire) begin
        ifmap_m2b_reg <= pe_ifmap;
        fltr_m2b_reg  <= pe_fltr;
      end
      // No backpressure: every result pulses for exactly one cycle.
      caster_valid_reg <= pe_valid;
      if (pe_valid) psum_m2b_reg <= pe_psum_res;
    end
  end

  assign ifmap_m2b    = ifmap_m2b_reg;
  assign fltr_m2b     = fltr_m2b_reg;
  assign psum_m2b     = psum_m2b_reg;
  assign caster_valid = caster_valid_reg;

endmodule

// File: tb/tb_tag_multicaster.sv
// Testbench for tag_multicaster: directed vectors, a queue-based model of
// the column's behaviour checked every cycle, and literal expectations.
module tb_tag_multicaster;

  localparam int DW    = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    id;
  logic [1:0]    bus_tag;
  logic [2:0]    bus_en;
  logic [DW-1:0] bus_ifmap;
  logic [DW-1:0] bus_fltr;
  logic [2*DW-1:0] bus_psum;
  logic          caster_ready;
  logic          caster_valid;
  logic [2*DW-1:0] psum_m2b;
  logic [DW-1:0] ifmap_m2b;
  logic [DW-1:0] fltr_m2b;
  logic          pe_en;
  logic          pe_ready;
  logic [DW-1:0] pe_ifmap;
  logic [DW-1:0] pe_fltr;
  logic [2*DW-1:0] pe_psum;
  logic          pe_valid;
  logic [2*DW-1:0] pe_psum_res;

  always #5 clk = ~clk;

  tag_multicaster #(.DATA_WIDTH(DW), .NUM_COL(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .id(id), .bus_tag(bus_tag), .bus_en(bus_en),
    .bus_ifmap(bus_ifmap), .bus_fltr(bus_fltr), .bus_psum(bus_psum),
`ifdef MCASTER_BCAST_EN
    .bus_bcast(1'b0),
`endif
    .caster_ready(caster_ready), .caster_valid(caster_valid),
    .psum_m2b(psum_m2b), .ifmap_m2b(ifmap_m2b), .fltr_m2b(fltr_m2b),
    .pe_en(pe_en), .pe_ready(pe_ready), .pe_ifmap(pe_ifmap),
    .pe_fltr(pe_fltr), .pe_psum(pe_psum), .pe_valid(pe_valid),
    .pe_psum_res(pe_psum_res)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0]   q_if[$];
  logic [DW-1:0]   q_fl[$];
  logic [2*DW-1:0] q_ps[$];
  logic [DW-1:0]   m_ifm2b;
  logic [DW-1:0]   m_flm2b;
  logic [2*DW-1:0] m_psm2b;
  logic [2*DW-1:0] m_drop;
  logic            m_cv;
  bit              m_on = 0;
  bit              m_room, m_fire, m_take;

  always @(posedge clk) begin
    if (rst) begin
      q_if.delete(); q_fl.delete(); q_ps.delete();
      m_ifm2b = '0; m_flm2b = '0; m_psm2b = '0; m_cv = 1'b0;
      m_on = 1;
    end else if (m_on) begin
      m_room = (q_if.size() < DEPTH) && (q_fl.size() < DEPTH) && (q_ps.size() < DEPTH);
      m_fire = (q_if.size() > 0) && (q_fl.size() > 0) && (q_ps.size() > 0) && pe_ready;
      m_take = (bus_tag == id) && m_room && (bus_en != 3'b000);
      if (m_fire) begin
        m_ifm2b = q_if.pop_front();
        m_flm2b = q_fl.pop_front();
        m_drop  = q_ps.pop_front();
      end
      if (m_take) begin
        if (bus_en[0]) q_if.push_back(bus_ifmap);
        if (bus_en[1]) q_fl.push_back(bus_fltr);
        if (bus_en[2]) q_ps.push_back(bus_psum);
      end
      m_cv = pe_valid;
      if (pe_valid) m_psm2b = pe_psum_res;
    end
  end

  // Every-cycle comparison, away from the active edge.
  logic exp_ready, exp_en;
  always @(negedge clk) begin
    if (m_on) begin
      exp_ready = !rst && (q_if.size() < DEPTH) && (q_fl.size() < DEPTH) && (q_ps.size() < DEPTH);
      exp_en    = (q_if.size() > 0) && (q_fl.size() > 0) && (q_ps.size() > 0);
      check("model_caster_ready", 32'(caster_ready), 32'(exp_ready));
      check("model_pe_en", 32'(pe_en), 32'(exp_en));
      if (exp_en && pe_en) begin
        check("model_pe_ifmap", 32'(pe_ifmap), 32'(q_if[0]));
        check("model_pe_fltr", 32'(pe_fltr), 32'(q_fl[0]));
        check("model_pe_psum", pe_psum, q_ps[0]);
      end
      check("model_caster_valid", 32'(caster_valid), 32'(m_cv));
      check("model_psum_m2b", psum_m2b, m_psm2b);
      check("model_ifmap_m2b", 32'(ifmap_m2b), 32'(m_ifm2b));
      check("model_fltr_m2b", 32'(fltr_m2b), 32'(m_flm2b));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] tag, input logic [2:0] en,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2*DW-1:0] c);
    bus_tag = tag; bus_en = en; bus_ifmap = a; bus_fltr = b; bus_psum = c;
  endtask

  initial begin
    rst = 1'b1; id = 2'd2; pe_ready = 1'b0; pe_valid = 1'b0; pe_psum_res = '0;
    drive(2'd0, 3'b000, '0, '0, '0);
    tick(); tick();
    check("reset_caster_ready_low", 32'(caster_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("after_reset_ready_high", 32'(caster_ready), 32'd1);
    check("after_reset_caster_valid", 32'(caster_valid), 32'd0);
    check("after_reset_psum_m2b", psum_m2b, 32'd0);
    $display("txn reset done");

    // Single matching triple issues the cycle after the push.
    pe_ready = 1'b1;
    drive(2'd2, 3'b111, 16'h0011, 16'h0022, 32'h0000_0033);
    tick();
    bus_en = 3'b000;
    check("t1_pe_en", 32'(pe_en), 32'd1);
    check("t1_pe_ifmap", 32'(pe_ifmap), 32'h0011);
    check("t1_pe_fltr", 32'(pe_fltr), 32'h0022);
    check("t1_pe_psum", pe_psum, 32'h0000_0033);
    tick();
    check("t1_pe_en_after", 32'(pe_en), 32'd0);
    check("t1_ifmap_m2b", 32'(ifmap_m2b), 32'h0011);
    check("t1_fltr_m2b", 32'(fltr_m2b), 32'h0022);
    $display("txn single triple issued");

    // Mismatched tag is dropped.
    drive(2'd1, 3'b111, 16'h0BAD, 16'h0BAD, 32'h0000_0BAD);
    tick();
    bus_en = 3'b000;
    check("t2_pe_en", 32'(pe_en), 32'd0);
    check("t2_caster_ready", 32'(caster_ready), 32'd1);
    $display("txn mismatched tag dropped");

    // Fill to depth, overflow word dropped, drain in order.
    pe_ready = 1'b0;
    drive(2'd2, 3'b111, 16'h0101, 16'h0202, 32'h0000_0303);
    tick();
    drive(2'd2, 3'b111, 16'h0404, 16'h0505, 32'h0000_0606);
    tick();
    check("t3_full_ready", 32'(caster_ready), 32'd0);
    drive(2'd2, 3'b111, 16'h0707, 16'h0808, 32'h0000_0909);
    tick();
    bus_en = 3'b000;
    pe_ready = 1'b1;
    check("t3_head_a", 32'(pe_ifmap), 32'h0101);
    tick();
    check("t3_head_b", 32'(pe_ifmap), 32'h0404);
    check("t3_head_b_psum", pe_psum, 32'h0000_0606);
    tick();
    check("t3_drained", 32'(pe_en), 32'd0);
    check("t3_last_m2b", 32'(ifmap_m2b), 32'h0404);
    $display("txn full/overflow/drain done");

    // Staggered classes.
    drive(2'd2, 3'b001, 16'h1111, 16'h0, 32'h0);
    tick(); bus_en = 3'b000;
    tick();
    drive(2'd2, 3'b010, 16'h0, 16'h2222, 32'h0);
    tick(); bus_en = 3'b000;
    tick();
    check("t4_not_yet", 32'(pe_en), 32'd0);
    drive(2'd2, 3'b100, 16'h0, 16'h0, 32'h0000_3333);
    tick(); bus_en = 3'b000;
    check("t4_pe_en", 32'(pe_en), 32'd1);
    check("t4_pe_fltr", 32'(pe_fltr), 32'h2222);
    tick();
    $display("txn staggered classes done");

    // Back-to-back results.
    pe_valid = 1'b1; pe_psum_res = 32'h1234_5678;
    tick();
    check("t5_valid0", 32'(caster_valid), 32'd1);
    check("t5_psum0", psum_m2b, 32'h1234_5678);
    pe_psum_res = 32'h9ABC_DEF0;
    tick();
    pe_valid = 1'b0;
    check("t5_valid1", 32'(caster_valid), 32'd1);
    check("t5_psum1", psum_m2b, 32'h9ABC_DEF0);
    tick();
    check("t5_valid_end", 32'(caster_valid), 32'd0);
    check("t5_psum_hold", psum_m2b, 32'h9ABC_DEF0);
    $display("txn result return done");

    // Reset with a buffered triple and a pending result.
    pe_ready = 1'b0;
    drive(2'd2, 3'b111, 16'h0AAA, 16'h0BBB, 32'h0000_0CCC);
    tick();
    bus_en = 3'b000;
    pe_valid = 1'b1; pe_psum_res = 32'hDEAD_BEEF; rst = 1'b1;
    tick();
    pe_valid = 1'b0;
    check("t6_pe_en", 32'(pe_en), 32'd0);
    check("t6_caster_valid", 32'(caster_valid), 32'd0);
    check("t6_psum_m2b", psum_m2b, 32'd0);
    check("t6_ready_in_reset", 32'(caster_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("t6_ready_after", 32'(caster_ready), 32'd1);
    $display("txn mid-operation reset done");

    // Streaming push+pop every cycle exercises pointer wrap.
    pe_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(2'd2, 3'b111, 16'(16'h0A00 + i), 16'(16'h0B00 + i), 32'(32'h0C00 + i));
      tick();
      $display("txn stream push %0d", i);
    end
    bus_en = 3'b000;
    tick();
    check("t7_last_m2b", 32'(ifmap_m2b), 32'h0A05);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
